inc_share_arbiter: RTL and testbench
====================================

// Module: inc_share_arbiter
// PURPOSE
//  Shares a single N-bit incrementor (out = in + 1) between NUM_REQ requesters.
//  Round-robin arbitration, valid/ready on each request port, one-entry output register.
//  Sits between producer blocks needing +1 operations and the consumer of the results.
//  Instantiates the team's combinational incrementor internally; overflow is derived here.
// PARAMETERS
//  N        4  data width in bits, legal range 4..8
//  NUM_REQ  4  number of requesters, legal range 2..4
//  IDW      2  width of rsp_id; must satisfy 2**IDW >= NUM_REQ
// PORTS
//  clk       in   1          single clock, rising edge
//  rst       in   1          synchronous, active-high reset
//  req_valid in   NUM_REQ    per-requester request valid
//  req_data  in   NUM_REQ*N  operands, flattened; requester i is [i*N +: N]
//  req_ready out  NUM_REQ    per-requester accept, one-hot or all-zero
//  rsp_valid out  1          result register holds a valid result
//  rsp_data  out  N          in + 1, modulo 2**N
//  rsp_id    out  IDW        index of the requester that issued the operand
//  rsp_ovf   out  1          1 when the operand was all ones (result wrapped to 0)
//  rsp_ready in   1          consumer accepts the result
// BEHAVIOUR
//  Reset (rst=1 at an edge): rsp_valid=0, rsp_data=0, rsp_id=0, rsp_ovf=0, RR pointer=0.
//   While rst=1, req_ready=0 (combinational gate).
//  State = rsp_valid. EMPTY (0) or FULL (1).
//  load_en = !rsp_valid | rsp_ready. A FULL register drained this cycle may be reloaded
//   in the same cycle (full throughput, 1 result per clock).
//  Arbitration (combinational): the winner is the first i with req_valid[i]=1, scanning
//   ptr, ptr+1, ..., wrapping at NUM_REQ. req_ready[winner] = load_en & !rst. All other
//   bits are 0. No valid request gives req_ready=0.
//  Accept = req_valid[w] & req_ready[w]. At that edge:
//   - rsp_data <= incr(req_data[w])
//   - rsp_ovf <= &req_data[w]
//   - rsp_id <= w
//   - rsp_valid <= 1
//   - ptr <= (w+1) mod NUM_REQ
//  Drain without accept (rsp_valid & rsp_ready, no winner): rsp_valid <= 0. The data,
//   id and ovf fields hold their last values.
//  FULL & !rsp_ready: all outputs hold and req_ready=0 (backpressure). ptr holds.
//  ptr changes only on accept.
//  Latency: accept at edge k gives a visible result after edge k, so 1 cycle.
//  Requester rules:
//   - Once req_valid is asserted, it and req_data stay stable until accepted.
//   - The arbiter does not depend on this.
//  Consumer rules: rsp_* stay stable while rsp_valid & !rsp_ready.
//  Width rules:
//   - Result wraps modulo 2**N, with no extra bit.
//   - rsp_ovf is the carry-out of bit N-1.
//  Reset mid-operation: a pending result is discarded and no requester sees an accept
//   that cycle. After reset, arbitration restarts at requester 0.
//  Fairness: with all requesters continuously valid and rsp_ready=1, grants go
//   0,1,...,NUM_REQ-1,0,... Maximum wait is NUM_REQ-1 grants.
// TESTING (N=4, NUM_REQ=4)
//  1. Reset, then req_valid=0001, data0=4'h3, rsp_ready=1 -> after 1 edge: rsp_valid=1,
//     rsp_data=4'h4, rsp_id=0, rsp_ovf=0. Next edge rsp_valid=0.
//  2. req_valid=1111 held, all data=4'h7, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0 on
//     consecutive cycles. rsp_valid stays 1. Exactly one req_ready bit high per cycle.
//  3. data2=4'hF, req_valid=0100 -> rsp_data=4'h0, rsp_ovf=1, rsp_id=2.
//     Then data2=4'hE -> rsp_data=4'hF, rsp_ovf=0.
//  4. Result FULL, rsp_ready=0 for 3 cycles with req_valid=0011 -> req_ready=0000 and
//     rsp_* constant. Raise rsp_ready -> the next accept occurs in that same cycle and
//     the new result appears after that edge.
//  5. rst=1 for one edge while FULL with req_valid=1000 -> rsp_valid=0, req_ready=0
//     during reset. The first post-reset grant goes to 3 (only valid), then ptr=0.
//  6. Random valid/ready traffic, 10k cycles, compared against a reference model:
//     - no lost or duplicated operands
//     - rsp_data == (op+1)%16
//     - per-requester order preserved

Source files
------------

// File: rtl/inc_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : inc_share_arbiter (with local helper inc_share_incr)
// Purpose  : Round-robin sharing of one N-bit +1 incrementor between NUM_REQ
//            valid/ready requesters, with a one-entry registered result stage.
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Combinational incrementor: o_sum = i_a + 1 modulo 2**N, carry out of bit N-1.
// ----------------------------------------------------------------------------
module inc_share_incr #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_a,
  output logic [N-1:0] o_sum,
  output logic         o_cout
);

  localparam logic [N:0] c_ONE = (N+1)'(1);

  logic [N:0] w_ext;

  // Widen by one bit so the wrap-around carry is captured explicitly
  assign w_ext  = {1'b0, i_a} + c_ONE;
  assign o_sum  = w_ext[N-1:0];
  assign o_cout = w_ext[N];

endmodule

// ----------------------------------------------------------------------------
// Arbiter top level.
// The result register is the only state besides the round-robin pointer:
// r_rsp_valid = 0 means EMPTY, 1 means FULL.
// ----------------------------------------------------------------------------
module inc_share_arbiter #(
  parameter int N       = 4,
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*N-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rsp_valid,
  output logic [N-1:0]         rsp_data,
  output logic [IDW-1:0]       rsp_id,
  output logic                 rsp_ovf,
  input  logic                 rsp_ready
);

  localparam logic [IDW-1:0] c_ID_ONE  = IDW'(1);
  localparam logic [IDW-1:0] c_ID_LAST = IDW'(NUM_REQ - 1);

  // Registered state
  logic               r_rsp_valid;
  logic [N-1:0]       r_rsp_data;
  logic [IDW-1:0]     r_rsp_id;
  logic               r_rsp_ovf;
  logic [IDW-1:0]     r_ptr;

  // Arbitration and datapath wires
  logic               w_found;
  logic [IDW-1:0]     w_win;
  logic [NUM_REQ-1:0] w_grant;
  logic [N-1:0]       w_op;
  logic [N-1:0]       w_sum;
  logic               w_cout;
  logic               w_load_en;
  logic               w_accept;

  // The register may take a new result when empty or when being drained now
  assign w_load_en = ~r_rsp_valid | rsp_ready;

  // Rotating priority search: first valid requester at or after the pointer
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!w_found && req_valid[j] && (j == ((int'(r_ptr) + k) % NUM_REQ))) begin
          w_found = 1'b1;
          w_win   = IDW'(j);
        end
      end
    end
  end

  // One-hot grant vector and operand selection for the winning requester
  always_comb begin
    w_grant = '0;
    w_op    = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (w_found && (IDW'(j) == w_win)) begin
        w_grant[j] = 1'b1;
        w_op       = req_data[j*N +: N];
      end
    end
  end

  // Ready is gated by reset so no requester sees an accept during reset
  assign req_ready = w_grant & {NUM_REQ{w_load_en & ~rst}};
  assign w_accept  = w_found & w_load_en & ~rst;

  inc_share_incr #(
    .N (N)
  ) u_incr (
    .i_a    (w_op),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Result register and round-robin pointer; pointer moves only on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
      r_rsp_ovf   <= 1'b0;
      r_ptr       <= '0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= w_sum;
      r_rsp_id    <= w_win;
      r_rsp_ovf   <= w_cout;
      r_ptr       <= (w_win == c_ID_LAST) ? '0 : (w_win + c_ID_ONE);
    end else if (r_rsp_valid && rsp_ready) begin
      // Drain with nothing to reload: payload fields keep their last value
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign rsp_ovf   = r_rsp_ovf;

endmodule

`default_nettype wire

// File: tb/tb_inc_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_inc_share_arbiter
// Purpose  : Directed vector table plus randomized traffic against a
//            rule-level reference model for inc_share_arbiter (N=4, NUM_REQ=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_inc_share_arbiter;

  localparam int N       = 4;
  localparam int NUM_REQ = 4;
  localparam int IDW     = 2;

  logic                 clk;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*N-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 rsp_valid;
  logic [N-1:0]         rsp_data;
  logic [IDW-1:0]       rsp_id;
  logic                 rsp_ovf;
  logic                 rsp_ready;

  int errors = 0;
  int checks = 0;

  inc_share_arbiter #(.N(N), .NUM_REQ(NUM_REQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_ovf   (rsp_ovf),
    .rsp_ready (rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs applied after a falling edge; expected values describe what is
  // visible before the following rising edge.
  typedef struct packed {
    logic        rst;
    logic [3:0]  vld;
    logic [15:0] data;
    logic        rdy;
    logic [3:0]  e_ready;
    logic        e_valid;
    logic [3:0]  e_data;
    logic [1:0]  e_id;
    logic        e_ovf;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic [3:0] v, input logic [15:0] d,
                     input logic rr, input logic [3:0] er, input logic ev,
                     input logic [3:0] ed, input logic [1:0] ei, input logic eo);
    vec_t t;
    t = '{rst: r, vld: v, data: d, rdy: rr, e_ready: er, e_valid: ev,
          e_data: ed, e_id: ei, e_ovf: eo};
    vq.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference arbitration: scan requesters from ptr with wrap, first valid wins
  function automatic int pick(input int ptr, input logic [3:0] v);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    end
    return -1;
  endfunction

  // Random-phase model state
  int          m_ptr;
  logic        m_valid;
  logic [3:0]  m_data;
  logic [1:0]  m_id;
  logic        m_ovf;
  logic [3:0]  pend;
  logic [3:0]  op [NUM_REQ];
  logic [3:0]  issued [NUM_REQ][$];
  int          n_rsp;

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);

    //    rst  vld      data      rdy  e_ready  ev  ed    id  ovf
    // single request, 1-cycle latency, drain
    add(1'b0, 4'b0000, 16'h0000, 1'b1, 4'b0000, 0, 4'h0, 0, 0); // reset state
    add(1'b0, 4'b0001, 16'h0003, 1'b1, 4'b0001, 0, 4'h0, 0, 0);
    add(1'b0, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1, 4'h4, 0, 0);
    add(1'b0, 4'b0000, 16'h0000, 1'b1, 4'b0000, 0, 4'h4, 0, 0);
    // reset to put pointer at 0, then fairness with all valid
    add(1'b1, 4'b1111, 16'h7777, 1'b1, 4'b0000, 0, 4'h4, 0, 0);
    add(1'b0, 4'b1111, 16'h7777, 1'b1, 4'b0001, 0, 4'h0, 0, 0);
    add(1'b0, 4'b1111, 16'h7777, 1'b1, 4'b0010, 1, 4'h8, 0, 0);
    add(1'b0, 4'b1111, 16'h7777, 1'b1, 4'b0100, 1, 4'h8, 1, 0);
    add(1'b0, 4'b1111, 16'h7777, 1'b1, 4'b1000, 1, 4'h8, 2, 0);
    add(1'b0, 4'b1111, 16'h7777, 1'b1, 4'b0001, 1, 4'h8, 3, 0);
    add(1'b0, 4'b0000, 16'h7777, 1'b1, 4'b0000, 1, 4'h8, 0, 0);
    // overflow wrap, then non-wrap
    add(1'b0, 4'b0100, 16'h0F00, 1'b1, 4'b0100, 0, 4'h8, 0, 0);
    add(1'b0, 4'b0100, 16'h0E00, 1'b1, 4'b0100, 1, 4'h0, 2, 1);
    add(1'b0, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1, 4'hF, 2, 0);
    // backpressure for three cycles, then same-cycle reload
    add(1'b0, 4'b0011, 16'h0021, 1'b0, 4'b0001, 0, 4'hF, 2, 0);
    add(1'b0, 4'b0011, 16'h0021, 1'b0, 4'b0000, 1, 4'h2, 0, 0);
    add(1'b0, 4'b0011, 16'h0021, 1'b0, 4'b0000, 1, 4'h2, 0, 0);
    add(1'b0, 4'b0011, 16'h0021, 1'b0, 4'b0000, 1, 4'h2, 0, 0);
    add(1'b0, 4'b0011, 16'h0021, 1'b1, 4'b0010, 1, 4'h2, 0, 0);
    add(1'b0, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1, 4'h3, 1, 0);
    // reset while FULL, pointer restarts at 0
    add(1'b0, 4'b1000, 16'h5000, 1'b0, 4'b1000, 0, 4'h3, 1, 0);
    add(1'b0, 4'b1000, 16'h5000, 1'b0, 4'b0000, 1, 4'h6, 3, 0);
    add(1'b1, 4'b1000, 16'h5000, 1'b0, 4'b0000, 1, 4'h6, 3, 0);
    add(1'b0, 4'b1000, 16'h5000, 1'b1, 4'b1000, 0, 4'h0, 0, 0);
    add(1'b0, 4'b1001, 16'h5009, 1'b1, 4'b0001, 1, 4'h6, 3, 0);
    add(1'b0, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1, 4'hA, 0, 0);

    foreach (vq[i]) begin
      @(negedge clk);
      rst       = vq[i].rst;
      req_valid = vq[i].vld;
      req_data  = vq[i].data;
      rsp_ready = vq[i].rdy;
      #1;
      chk($sformatf("vec%0d", i),
          {21'd0, req_ready, rsp_valid, rsp_data, rsp_id, rsp_ovf},
          {21'd0, vq[i].e_ready, vq[i].e_valid, vq[i].e_data, vq[i].e_id, vq[i].e_ovf});
    end

    // Randomized traffic
    @(negedge clk);
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0; m_valid = 1'b0; m_data = '0; m_id = '0; m_ovf = 1'b0;
    pend = '0; n_rsp = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      op[i] = '0;
      issued[i].delete();
    end

    for (int cyc = 0; cyc < 10000; cyc++) begin
      int   w;
      logic ld;
      logic [3:0] er;
      if (cyc != 0) @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i] = 1'b1;
          op[i]   = 4'($urandom_range(0, 15));
          issued[i].push_back(op[i]);
        end
      end
      req_valid = pend;
      req_data  = {op[3], op[2], op[1], op[0]};
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;

      w  = pick(m_ptr, pend);
      ld = !m_valid || rsp_ready;
      er = (w >= 0 && ld) ? 4'(1 << w) : 4'b0000;
      if (req_ready !== er || rsp_valid !== m_valid || rsp_data !== m_data ||
          rsp_id !== m_id || rsp_ovf !== m_ovf) begin
        chk($sformatf("rand_cyc%0d", cyc),
            {23'd0, req_ready, rsp_valid, rsp_data, rsp_id, rsp_ovf},
            {23'd0, er, m_valid, m_data, m_id, m_ovf});
      end else begin
        checks++;
      end

      // Scoreboard: each delivered result matches the oldest op of that requester
      if (rsp_valid === 1'b1 && rsp_ready) begin
        n_rsp++;
        if (issued[rsp_id].size() == 0) begin
          chk($sformatf("dup_id%0d_cyc%0d", rsp_id, cyc), 32'd1, 32'd0);
        end else begin
          logic [3:0] o;
          o = issued[rsp_id].pop_front();
          chk($sformatf("sb_cyc%0d", cyc), {27'd0, rsp_ovf, rsp_data},
              {27'd0, (o == 4'hF), 4'((int'(o) + 1) % 16)});
        end
      end

      if (w >= 0 && ld) begin
        m_valid = 1'b1;
        m_data  = 4'((int'(op[w]) + 1) % 16);
        m_ovf   = (op[w] == 4'hF);
        m_id    = 2'(w);
        m_ptr   = (w + 1) % NUM_REQ;
        pend[w] = 1'b0;
      end else if (m_valid && rsp_ready) begin
        m_valid = 1'b0;
      end
    end

    // Nothing lost: every outstanding op is either still waiting or in the register
    begin
      int outstanding;
      outstanding = 0;
      for (int i = 0; i < NUM_REQ; i++) outstanding += issued[i].size();
      chk("no_lost_ops", 32'(outstanding), 32'($countones(pend)) + (m_valid ? 32'd1 : 32'd0));
      chk("rsp_count_nonzero", (n_rsp > 1000) ? 32'd1 : 32'd0, 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
